// File: rtl/ring_slot_sequencer.sv
// ring_slot_sequencer
// Time-division arbiter driven by a 4-bit one-hot ring counter. Each slot
// offers a single registered valid/ready output stage to one of four
// requesters. The block also counts completed ring laps.
// Optional feature macro: RING_SLOT_PHASE_CHECK_EN. When it is defined, a
// phase vector that is not one-hot blocks the accept and the lap increment,
// and sets the sticky phase_err flag. When it is undefined, phase_err is
// tied to 0 and the lowest set phase bit picks the slot.

module ring_slot_sequencer #(
    parameter int DATA_W = 8,
    parameter int LAP_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            phase,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [3:0]            ack,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    input  logic                  out_ready,
    output logic [LAP_W-1:0]      lap_count,
    output logic                  phase_err
);

    // True when exactly one bit of a 4-bit vector is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    logic [1:0]        slot_s;
    logic              slot_ok_s;
    logic              lap_ok_s;
    logic              accept_s;
    logic [DATA_W-1:0] word_s;
    logic              phase3_r;

    // Find the active slot: the lowest set phase bit, plus whether the slot is usable.
    always_comb begin
        slot_s = 2'd0;
        if (phase[0]) begin
            slot_s = 2'd0;
        end else if (phase[1]) begin
            slot_s = 2'd1;
        end else if (phase[2]) begin
            slot_s = 2'd2;
        end else begin
            slot_s = 2'd3;
        end
`ifdef RING_SLOT_PHASE_CHECK_EN
        slot_ok_s = is_onehot4(phase);
        lap_ok_s  = is_onehot4(phase);
`else
        slot_ok_s = |phase;
        lap_ok_s  = 1'b1;
`endif
    end

    // Select the word offered in the active slot.
    always_comb begin
        word_s = '0;
        case (slot_s)
            2'd0:    word_s = data_in[0*DATA_W +: DATA_W];
            2'd1:    word_s = data_in[1*DATA_W +: DATA_W];
            2'd2:    word_s = data_in[2*DATA_W +: DATA_W];
            2'd3:    word_s = data_in[3*DATA_W +: DATA_W];
            default: word_s = '0;
        endcase
    end

    // Accept when the slot owner requests and the output stage is free or draining.
    always_comb begin
        accept_s = slot_ok_s && req[slot_s] && (!out_valid || out_ready);
    end

    // Output stage: load on accept, drain on ready, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            ack       <= 4'b0000;
        end else begin
            if (accept_s) begin
                out_valid <= 1'b1;
                out_data  <= word_s;
                out_src   <= slot_s;
                ack       <= 4'b0001 << slot_s;
            end else begin
                ack <= 4'b0000;
                if (out_ready) begin
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= out_valid;
                end
            end
        end
    end

    // Lap counter: a lap completes when phase wraps from slot 3 back to slot 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase3_r  <= 1'b0;
            lap_count <= '0;
        end else begin
            phase3_r <= phase[3];
            if (phase3_r && phase[0] && lap_ok_s) begin
                lap_count <= lap_count + LAP_W'(1);
            end else begin
                lap_count <= lap_count;
            end
        end
    end

    // Sticky phase-integrity flag; cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_err <= 1'b0;
        end else begin
`ifdef RING_SLOT_PHASE_CHECK_EN
            if (!is_onehot4(phase)) begin
                phase_err <= 1'b1;
            end else begin
                phase_err <= phase_err;
            end
`else
            phase_err <= 1'b0;
`endif
        end
    end

endmodule
